// File: rtl/pipe_stage_skid_if.sv
// ============================================================
// Module   : pipe_stage_skid_if
// Purpose  : valid/ready link carrying payload + control bits
// Revision : 1.0
// ============================================================
`default_nettype none

interface pipe_stage_skid_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  // master is the producing side, slave the consuming side
  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================
// Module   : pipe_stage_skid
// Purpose  : pipeline stage register, optional 2-entry skid,
//            flush-to-bubble and saturating stall counter
// Revision : 1.0
// ============================================================
`default_nettype none

module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  output logic             out_noop,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_cntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_mValid;
  logic [DATA_W-1:0] r_mData;
  logic [CTRL_W-1:0] r_mCtrl;
  logic [CNT_W-1:0]  r_stallCnt;
  logic              w_inReady;
  logic              w_inXfer;
  logic              w_outXfer;

  assign w_outXfer = r_mValid & dn.ready;
  // a flush cycle reports ready but never keeps the incoming entry
  assign w_inXfer  = up.valid & w_inReady & ~flush;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_sValid;
      logic [DATA_W-1:0] r_sData;
      logic [CTRL_W-1:0] r_sCtrl;

      assign w_inReady = ~r_sValid | flush;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_mValid <= 1'b0;
          r_mData  <= '0;
          r_mCtrl  <= '0;
          r_sValid <= 1'b0;
          r_sData  <= '0;
          r_sCtrl  <= '0;
        end else if (flush) begin
          r_mValid <= 1'b0;
          r_mCtrl  <= '0;
          r_sValid <= 1'b0;
          r_sCtrl  <= '0;
        end else if (!r_mValid || w_outXfer) begin
          // main is free this cycle: the older skid entry has priority
          if (r_sValid) begin
            r_mValid <= 1'b1;
            r_mData  <= r_sData;
            r_mCtrl  <= r_sCtrl;
            r_sValid <= 1'b0;
            r_sCtrl  <= '0;
          end else if (w_inXfer) begin
            r_mValid <= 1'b1;
            r_mData  <= up.data;
            r_mCtrl  <= up.ctrl;
          end else begin
            r_mValid <= 1'b0;
            r_mCtrl  <= '0;
          end
        end else if (w_inXfer) begin
          r_sValid <= 1'b1;
          r_sData  <= up.data;
          r_sCtrl  <= up.ctrl;
        end
      end
    end else begin : g_noSkid
      assign w_inReady = ~r_mValid | dn.ready | flush;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_mValid <= 1'b0;
          r_mData  <= '0;
          r_mCtrl  <= '0;
        end else if (flush) begin
          r_mValid <= 1'b0;
          r_mCtrl  <= '0;
        end else if (w_inXfer) begin
          r_mValid <= 1'b1;
          r_mData  <= up.data;
          r_mCtrl  <= up.ctrl;
        end else if (w_outXfer) begin
          r_mValid <= 1'b0;
          r_mCtrl  <= '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCnt <= '0;
    end else if (r_mValid && !dn.ready && (r_stallCnt != c_cntMax)) begin
      r_stallCnt <= r_stallCnt + c_cntOne;
    end
  end

  assign up.ready  = w_inReady;
  assign dn.valid  = r_mValid;
  assign dn.data   = r_mData;
  assign dn.ctrl   = r_mValid ? r_mCtrl : '0;
  assign out_noop  = ~r_mValid;
  assign stall_cnt = r_stallCnt;

endmodule

`default_nettype wire
